dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory between the CPU load/store port and a debug/host port. A host can then preload or inspect data memory while the core runs, instead of relying on simulator backdoor access. It sits between the CPU datapath and data memory. It owns a small FSM that sequences one-cycle writes and two-cycle reads, and stalls the CPU whenever the CPU does not own the memory.

---
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU load/store port and a debug port.
// Writes complete in the grant cycle; reads return data one cycle later.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    input  logic [DW/8-1:0] cpu_be,
    output logic            cpu_stall,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_rvalid,
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [DW-1:0]   dbg_wdata,
    input  logic [DW/8-1:0] dbg_be,
    output logic            dbg_gnt,
    output logic [DW-1:0]   dbg_rdata,
    output logic            dbg_rvalid,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD_CPU,
        RD_DBG
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          last_owner;
    logic          last_nx;
    logic          cpu_win;
    logic          dbg_win;
    logic [DW-1:0] cpu_hold;
    logic [DW-1:0] dbg_hold;

    always_comb begin
        state_nx = state;
        last_nx  = last_owner;
        cpu_win  = 1'b0;
        dbg_win  = 1'b0;
        unique case (state)
            IDLE: begin
                // last_owner = 1 means DBG went last, so CPU wins a tie
                cpu_win = cpu_req & (~dbg_req | last_owner);
                dbg_win = dbg_req & ~cpu_win;
                if (cpu_win) begin
                    last_nx = 1'b0;
                    if (!cpu_we) state_nx = RD_CPU;
                end else if (dbg_win) begin
                    last_nx = 1'b1;
                    if (!dbg_we) state_nx = RD_DBG;
                end
            end
            RD_CPU:  state_nx = IDLE;
            RD_DBG:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = rst & (cpu_win | dbg_win);
        mem_we    = mem_en & (dbg_win ? dbg_we : cpu_we);
        mem_addr  = dbg_win ? dbg_addr  : cpu_addr;
        mem_wdata = dbg_win ? dbg_wdata : cpu_wdata;
        mem_be    = dbg_win ? dbg_be    : cpu_be;
    end

    assign cpu_rvalid = (state == RD_CPU);
    assign dbg_rvalid = (state == RD_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_hold;

    assign cpu_stall = rst & cpu_req & ~((cpu_win & cpu_we) | cpu_rvalid);
    assign dbg_gnt   = rst & dbg_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            cpu_hold   <= '0;
            dbg_hold   <= '0;
        end else begin
            state      <= state_nx;
            last_owner <= last_nx;
            if (cpu_rvalid) cpu_hold <= mem_rdata;
            if (dbg_rvalid) dbg_hold <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Random + directed bench for dmem_arbiter with a transaction-level model
// and a decoupled scoreboard monitor.
module tb_dmem_arbiter;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    typedef struct {
        bit          en;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          gd;
        bit          stall;
        bit          cv;
        bit          dv;
        logic [31:0] crd;
        logic [31:0] drd;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [3:0]  dbg_be;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:63];
    logic [31:0] mdl [0:63];

    txn_t        cq[$];
    txn_t        dq[$];
    rec_t        exp_q[$];
    logic [31:0] cpu_q[$];
    logic [31:0] dbg_q[$];

    txn_t        c_cur, d_cur;
    bit          c_act, d_act;
    bit          rnd_on;
    bit          mon_on;
    int          last;
    int          pend;
    logic [31:0] pend_data;
    logic [31:0] hold_c, hold_d;

    int total;
    int bad;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_be(dbg_be), .dbg_gnt(dbg_gnt),
        .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: write on grant edge, read data next cycle
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b])
                        ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[7:2]];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = 32'($urandom_range(0, 15)) << 2;
        t.wdata = $urandom;
        t.be    = 4'($urandom_range(0, 15));
        return t;
    endfunction

    task automatic model_write(input txn_t t);
        for (int b = 0; b < 4; b++)
            if (t.be[b]) mdl[t.addr[7:2]][8*b +: 8] = t.wdata[8*b +: 8];
    endtask

    // Drive this cycle's requests and predict the arbiter's response
    task automatic drive_and_model();
        rec_t r;
        txn_t t;
        bit   cw;
        bit   dw;
        cw = 1'b0;
        dw = 1'b0;
        if (!c_act) begin
            if (cq.size() > 0) begin
                c_cur = cq.pop_front(); c_act = 1'b1;
            end else if (rnd_on && $urandom_range(0, 3) != 0) begin
                c_cur = rand_txn(); c_act = 1'b1;
            end
        end
        if (!d_act) begin
            if (dq.size() > 0) begin
                d_cur = dq.pop_front(); d_act = 1'b1;
            end else if (rnd_on && $urandom_range(0, 3) != 0) begin
                d_cur = rand_txn(); d_act = 1'b1;
            end
        end
        cpu_req   = c_act;
        cpu_we    = c_act ? c_cur.we : 1'b0;
        cpu_addr  = c_act ? c_cur.addr : 32'h0;
        cpu_wdata = c_act ? c_cur.wdata : 32'h0;
        cpu_be    = c_act ? c_cur.be : 4'h0;
        dbg_req   = d_act;
        dbg_we    = d_act ? d_cur.we : 1'b0;
        dbg_addr  = d_act ? d_cur.addr : 32'h0;
        dbg_wdata = d_act ? d_cur.wdata : 32'h0;
        dbg_be    = d_act ? d_cur.be : 4'h0;

        r = '{default: '0};
        r.crd = hold_c;
        r.drd = hold_d;
        if (pend == 1) begin
            r.cv = 1'b1; r.crd = pend_data; hold_c = pend_data;
            cpu_q.push_back(pend_data); c_act = 1'b0; pend = 0;
        end else if (pend == 2) begin
            r.dv = 1'b1; r.drd = pend_data; hold_d = pend_data;
            dbg_q.push_back(pend_data); d_act = 1'b0; pend = 0;
        end else begin
            cw = c_act && (!d_act || last == 1);
            dw = d_act && !cw;
            if (cw || dw) begin
                t = cw ? c_cur : d_cur;
                r.en = 1'b1; r.we = t.we; r.addr = t.addr;
                r.wdata = t.wdata; r.be = t.be; r.gd = dw;
                last = cw ? 0 : 1;
                if (t.we) begin
                    model_write(t);
                    if (cw) c_act = 1'b0; else d_act = 1'b0;
                end else begin
                    pend = cw ? 1 : 2;
                    pend_data = mdl[t.addr[7:2]];
                end
            end
        end
        r.stall = cpu_req && !(cw && c_cur.we) && !r.cv;
        exp_q.push_back(r);
    endtask

    // Monitor: compares DUT against the predicted per-cycle record
    initial begin
        rec_t        r;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (mon_on && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("mem_en", mem_en, r.en);
                chk("dbg_gnt", dbg_gnt, r.gd);
                chk("cpu_stall", cpu_stall, r.stall);
                chk("cpu_rvalid", cpu_rvalid, r.cv);
                chk("dbg_rvalid", dbg_rvalid, r.dv);
                chk("cpu_rdata", cpu_rdata, r.crd);
                chk("dbg_rdata", dbg_rdata, r.drd);
                if (r.en) begin
                    chk("mem_we", mem_we, r.we);
                    chk("mem_addr", mem_addr, r.addr);
                    chk("mem_wdata", mem_wdata, r.wdata);
                    chk("mem_be", mem_be, r.be);
                end
                if (cpu_rvalid) begin
                    e = (cpu_q.size() > 0) ? cpu_q.pop_front() : 32'hx;
                    chk("cpu_load_sb", cpu_rdata, e);
                end
                if (dbg_rvalid) begin
                    e = (dbg_q.size() > 0) ? dbg_q.pop_front() : 32'hx;
                    chk("dbg_load_sb", dbg_rdata, e);
                end
            end
        end
    end

    initial begin
        total = 0; bad = 0;
        c_act = 0; d_act = 0; rnd_on = 0; mon_on = 1;
        last = 1; pend = 0; pend_data = '0; hold_c = '0; hold_d = '0;
        c_cur = '{default: '0}; d_cur = '{default: '0};
        mem_rdata = '0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom;
            mdl[i] = ram[i];
        end
        ram[8] = 32'h12345678;
        mdl[8] = 32'h12345678;

        rst = 1'b0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h4; cpu_wdata = 32'h1; cpu_be = 4'hF;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h8; dbg_wdata = 32'h2; dbg_be = 4'hF;
        #3;
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_dbg_gnt", dbg_gnt, 1'b0);
        chk("rst_cpu_stall", cpu_stall, 1'b0);
        chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);

        cq.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF});
        cq.push_back('{1'b0, 32'h10, 32'h0, 4'hF});
        cq.push_back('{1'b0, 32'h0, 32'h0, 4'hF});
        dq.push_back('{1'b1, 32'h0, 32'h0000AB00, 4'b0010});
        dq.push_back('{1'b0, 32'h20, 32'h0, 4'hF});
        for (int i = 0; i < 4; i++) begin
            cq.push_back('{1'b1, 32'(i * 4 + 64), 32'(i + 100), 4'hF});
            dq.push_back('{1'b1, 32'(i * 4 + 128), 32'(i + 200), 4'hF});
        end

        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            rst = 1'b1;
            rnd_on = (i >= 40 && i < 450);
            drive_and_model();
        end
        for (int i = 0; i < 10 && (c_act || d_act || pend != 0); i++) begin
            @(negedge clk);
            drive_and_model();
        end
        chk("drain_idle", {30'b0, c_act | d_act, pend != 0}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            drive_and_model();
        end
        @(negedge clk);
        #5;
        chk("cpu_q_left", cpu_q.size(), 0);
        chk("dbg_q_left", dbg_q.size(), 0);
        mon_on = 0;

        // Reset in the middle of a CPU read drops the read
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_be = 4'hF;
        dbg_req = 0;
        #3;
        chk("mr_grant_en", mem_en, 1'b1);
        chk("mr_grant_stall", cpu_stall, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mr_rst_rvalid", cpu_rvalid, 1'b0);
        chk("mr_rst_mem_en", mem_en, 1'b0);
        chk("mr_rst_stall", cpu_stall, 1'b0);
        chk("mr_rst_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
        #3;
        chk("mr_rel_rvalid", cpu_rvalid, 1'b0);
        chk("mr_rel_mem_en", mem_en, 1'b1);
        chk("mr_rel_dbg_gnt", dbg_gnt, 1'b0);
        chk("mr_rel_addr", mem_addr, 32'h10);
        chk("mr_rel_stall", cpu_stall, 1'b1);
        @(negedge clk);
        cpu_req = 0; dbg_req = 0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
